// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and RAW/WAW scoreboard for the 32x32 register file write port.
// Define RF_WB_FWD_EN to forward the committing write to decode and drop its stall cycle.
module rf_wb_arbiter #(
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          fwd1_valid,
    output logic          fwd2_valid,
    output logic [DW-1:0] fwd1_data,
    output logic [DW-1:0] fwd2_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    logic            prio;
    logic [NREG-1:0] busy;
    logic            gnt0;
    logic            gnt1;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic            iss_fire;

    // Grants are suppressed during reset so nothing is consumed that reset will discard.
    always_comb begin
        gnt0 = rst_n && req0_valid && (!req1_valid || !prio);
        gnt1 = rst_n && req1_valid && (!req0_valid || prio);
        gnt_addr = gnt1 ? req1_addr : req0_addr;
        gnt_data = gnt1 ? req1_data : req0_data;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign iss_ready = !busy[iss_rd] || (iss_rd == '0);
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
        end else begin
            rf_we <= (gnt0 || gnt1) && (gnt_addr != '0);
            if (gnt0 || gnt1) begin
                prio     <= gnt0;
                rf_waddr <= gnt_addr;
                rf_wdata <= gnt_data;
            end
            // Clear first so a same-edge issue to the committing register keeps it busy.
            if (rf_we) begin
                busy[rf_waddr] <= 1'b0;
            end
            if (iss_fire) begin
                busy[iss_rd] <= 1'b1;
            end
        end
    end

`ifdef RF_WB_FWD_EN
    logic hit1;
    logic hit2;

    always_comb begin
        hit1 = rf_we && (rf_waddr == rs1_addr) && (rs1_addr != '0);
        hit2 = rf_we && (rf_waddr == rs2_addr) && (rs2_addr != '0);
        rs1_busy   = busy[rs1_addr] && (!hit1 || (iss_fire && (iss_rd == rs1_addr)));
        rs2_busy   = busy[rs2_addr] && (!hit2 || (iss_fire && (iss_rd == rs2_addr)));
        fwd1_valid = hit1;
        fwd2_valid = hit2;
        fwd1_data  = hit1 ? rf_wdata : '0;
        fwd2_data  = hit2 ? rf_wdata : '0;
    end
`else
    assign rs1_busy   = busy[rs1_addr];
    assign rs2_busy   = busy[rs2_addr];
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; expectations follow RF_WB_FWD_EN when defined.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd, rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef RF_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    rf_wb_arbiter #(.AW(5), .DW(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAAAA;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hBBBB;
        iss_valid = 1'b0; iss_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;

        // Reset held for three cycles with both requests pending
        repeat (3) tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_iss_ready", iss_ready, 1);
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_fwd1_valid", fwd1_valid, 0);
        chk("rst_fwd2_data", fwd2_data, 0);

        // Round-robin: req0 first, then alternate
        rst_n = 1'b1; #1;
        chk("rr_g0_req0", req0_ready, 1);
        chk("rr_g0_req1", req1_ready, 0);
        tick();
        chk("rr_we1", rf_we, 1);
        chk("rr_waddr1", rf_waddr, 5);
        chk("rr_wdata1", rf_wdata, 32'hAAAA);
        chk("rr_g1_req1", req1_ready, 1);
        chk("rr_g1_req0", req0_ready, 0);
        tick();
        chk("rr_waddr2", rf_waddr, 6);
        chk("rr_wdata2", rf_wdata, 32'hBBBB);
        chk("rr_g2_req0", req0_ready, 1);
        tick();
        chk("rr_waddr3", rf_waddr, 5);
        chk("rr_g3_req1", req1_ready, 1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; #1;
        chk("rr_waddr4", rf_waddr, 6);
        chk("rr_we4", rf_we, 1);
        chk("rr_idle_req0", req0_ready, 0);
        chk("rr_idle_req1", req1_ready, 0);
        tick();
        chk("rr_idle_we", rf_we, 0);

        // Scoreboard: issue r7, block re-issue, clear via req1 write
        iss_valid = 1'b1; iss_rd = 5'd7; #1;
        chk("sb_iss_ready_r7", iss_ready, 1);
        chk("sb_rs1_prebusy", rs1_busy, 0);
        tick();
        chk("sb_rs1_busy", rs1_busy, 1);
        chk("sb_waw_stall", iss_ready, 0);
        iss_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h1234; #1;
        chk("sb_req1_grant", req1_ready, 1);
        tick();
        req1_valid = 1'b0; #1;
        chk("sb_we_r7", rf_we, 1);
        chk("sb_waddr_r7", rf_waddr, 7);
        chk("sb_wdata_r7", rf_wdata, 32'h1234);
        chk("sb_rs1_busy_t1", rs1_busy, FWD ? 0 : 1);
        chk("sb_fwd1_valid_t1", fwd1_valid, FWD ? 1 : 0);
        chk("sb_fwd1_data_t1", fwd1_data, FWD ? 32'h1234 : 0);
        tick();
        chk("sb_rs1_clear_t2", rs1_busy, 0);
        chk("sb_iss_ready_t2", iss_ready, 1);

        // Zero register: write consumed without rf_we, issue ignored
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h55; #1;
        chk("z_req0_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0; #1;
        chk("z_rf_we", rf_we, 0);
        iss_valid = 1'b1; iss_rd = 5'd0; #1;
        chk("z_iss_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0; rs1_addr = 5'd0; #1;
        chk("z_rs1_busy_r0", rs1_busy, 0);
        rs1_addr = 5'd7; #1;
        chk("z_rs1_busy_r7", rs1_busy, 0);

        // Collision: commit to r9 while issuing r9 keeps r9 busy
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99; #1;
        chk("col_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9; rs2_addr = 5'd9; #1;
        chk("col_we", rf_we, 1);
        chk("col_iss_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0; #1;
        chk("col_rs2_busy", rs2_busy, 1);
        chk("col_waw", iss_ready, 0);

        // Forwarding on rs2 for r3 = 0xDEAD
        iss_valid = 1'b1; iss_rd = 5'd3; rs2_addr = 5'd3; #1;
        tick();
        iss_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'hDEAD; #1;
        chk("fwd_pre_busy", rs2_busy, 1);
        chk("fwd_req1_grant", req1_ready, 1);
        tick();
        req1_valid = 1'b0; #1;
        chk("fwd_we", rf_we, 1);
        chk("fwd_rs2_busy", rs2_busy, FWD ? 0 : 1);
        chk("fwd2_valid", fwd2_valid, FWD ? 1 : 0);
        chk("fwd2_data", fwd2_data, FWD ? 32'hDEAD : 0);
        chk("fwd1_idle", fwd1_valid, 0);
        tick();
        chk("fwd_after_busy", rs2_busy, 0);

        // Mid-operation reset discards a pending grant and clears busy
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h4444; rs2_addr = 5'd9; rst_n = 1'b0; #1;
        chk("mrst_req0_ready", req0_ready, 0);
        tick();
        req0_valid = 1'b0; rst_n = 1'b1; #1;
        chk("mrst_we", rf_we, 0);
        chk("mrst_rs2_busy", rs2_busy, 0);
        tick();
        chk("mrst_we_after", rf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
